// File: rtl/sram_pattern_tester.sv
// SRAM self-test master: full-range write/read passes over four data patterns,
// optional looping with odd-pass inversion, and in-order read-return checking.
// Optional feature macro: ERR_CAPTURE_EN adds first-mismatch capture outputs
// err_addr/err_exp/err_got.
module sram_pattern_tester #(
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_LAST = (1 << ADDR_W) - 1,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_en,
  input  logic [1:0]            pattern,
  output logic                  ram_req,
  input  logic                  ram_ready,
  output logic                  ram_rd,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [DATA_W/8-1:0]   ram_be,
  output logic [DATA_W-1:0]     ram_wr_data,
  input  logic                  ram_rd_data_vld,
  input  logic [DATA_W-1:0]     ram_rd_data,
  output logic                  busy,
  output logic                  ram_match,
  output logic                  ram_mismatch,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      pass_count
`ifdef ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0]     err_addr,
  output logic [DATA_W-1:0]     err_exp,
  output logic [DATA_W-1:0]     err_got
`endif
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned OUT_W = 4;
  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(ADDR_LAST);
  localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUTST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   chk_addr_q, chk_addr_d;
  logic [1:0]          pat_q, pat_d;
  logic                loop_q, loop_d;
  logic                odd_q, odd_d;
  logic [OUT_W-1:0]    outst_q, outst_d;
  logic                pass_err_q, pass_err_d;
  logic                req_q, req_d;
  logic                rd_q, rd_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                match_q, match_d;
  logic                mism_q, mism_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic [CNT_W-1:0]    pass_count_q, pass_count_d;
  logic [BE_W-1:0]     be_q;
`ifdef ERR_CAPTURE_EN
  logic                cap_done_q, cap_done_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [DATA_W-1:0]   err_exp_q, err_exp_d;
  logic [DATA_W-1:0]   err_got_q, err_got_d;
`endif

  // Expected word for address a, pattern pat, inverted on odd passes.
  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0]        pat,
                                                 input logic              odd);
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] one;
    logic [ADDR_W-1:0] bit_idx;
    one     = DATA_W'(1);
    bit_idx = a % ADDR_W'(DATA_W);
    case (pat)
      2'd0:    base = DATA_W'(a);
      2'd1:    base = one << bit_idx;
      2'd2:    base = a[0] ? {BE_W{8'hAA}} : {BE_W{8'h55}};
      default: base = ~DATA_W'(a);
    endcase
    return base ^ {DATA_W{odd}};
  endfunction

  logic accept;
  logic chk_vld;
  logic chk_bad;
  logic inc;
  logic dec;
  logic [DATA_W-1:0] chk_exp;

  assign accept  = req_q & ram_ready;
  assign chk_vld = ram_rd_data_vld & ((state_q == ST_READ) | (state_q == ST_DRAIN));
  assign chk_exp = exp_data(chk_addr_q, pat_q, odd_q);
  assign chk_bad = chk_vld & (ram_rd_data != chk_exp);
  assign inc     = accept & rd_q & (state_q == ST_READ);
  assign dec     = chk_vld & (outst_q != '0);

  // Next-state, request generation and read-return checking.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    chk_addr_d   = chk_addr_q;
    pat_d        = pat_q;
    loop_d       = loop_q;
    odd_d        = odd_q;
    outst_d      = outst_q + OUT_W'(inc) - OUT_W'(dec);
    pass_err_d   = pass_err_q;
    req_d        = req_q;
    rd_d         = rd_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    match_d      = 1'b0;
    mism_d       = 1'b0;
    err_count_d  = err_count_q;
    pass_count_d = pass_count_q;
`ifdef ERR_CAPTURE_EN
    cap_done_d   = cap_done_q;
    err_addr_d   = err_addr_q;
    err_exp_d    = err_exp_q;
    err_got_d    = err_got_q;
`endif

    // Check returning read data in order.
    if (chk_vld) begin
      chk_addr_d = chk_addr_q + ADDR_W'(1);
      if (chk_bad) begin
        mism_d     = 1'b1;
        pass_err_d = 1'b1;
        if (err_count_q != {CNT_W{1'b1}}) begin
          err_count_d = err_count_q + CNT_W'(1);
        end
`ifdef ERR_CAPTURE_EN
        if (!cap_done_q) begin
          cap_done_d = 1'b1;
          err_addr_d = chk_addr_q;
          err_exp_d  = chk_exp;
          err_got_d  = ram_rd_data;
        end
`endif
      end
    end

    case (state_q)
      ST_IDLE: begin
        req_d = 1'b0;
        rd_d  = 1'b0;
        if (start) begin
          state_d      = ST_WRITE;
          pat_d        = pattern;
          loop_d       = loop_en;
          odd_d        = 1'b0;
          addr_d       = '0;
          chk_addr_d   = '0;
          outst_d      = '0;
          pass_err_d   = 1'b0;
          err_count_d  = '0;
          pass_count_d = '0;
          busy_d       = 1'b1;
          req_d        = 1'b1;
          wr_data_d    = exp_data('0, pattern, 1'b0);
`ifdef ERR_CAPTURE_EN
          cap_done_d   = 1'b0;
          err_addr_d   = '0;
          err_exp_d    = '0;
          err_got_d    = '0;
`endif
        end
      end

      ST_WRITE: begin
        req_d = 1'b1;
        rd_d  = 1'b0;
        if (accept) begin
          if (addr_q == ADDR_END) begin
            state_d = ST_READ;
            addr_d  = '0;
            rd_d    = 1'b1;
          end else begin
            addr_d    = addr_q + ADDR_W'(1);
            wr_data_d = exp_data(addr_q + ADDR_W'(1), pat_q, odd_q);
          end
        end
      end

      ST_READ: begin
        rd_d = 1'b1;
        if (accept && (addr_q == ADDR_END)) begin
          state_d = ST_DRAIN;
          req_d   = 1'b0;
          rd_d    = 1'b0;
        end else begin
          if (accept) begin
            addr_d = addr_q + ADDR_W'(1);
          end
          req_d = (outst_d != OUT_MAX);
        end
      end

      default: begin
        req_d = 1'b0;
        rd_d  = 1'b0;
        if (outst_q == '0) begin
          pass_count_d = pass_count_q + CNT_W'(1);
          match_d      = ~pass_err_d;
          if (loop_q && !stop) begin
            state_d    = ST_WRITE;
            odd_d      = ~odd_q;
            addr_d     = '0;
            chk_addr_d = '0;
            pass_err_d = 1'b0;
            req_d      = 1'b1;
            wr_data_d  = exp_data('0, pat_q, ~odd_q);
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      chk_addr_q   <= '0;
      pat_q        <= '0;
      loop_q       <= 1'b0;
      odd_q        <= 1'b0;
      outst_q      <= '0;
      pass_err_q   <= 1'b0;
      req_q        <= 1'b0;
      rd_q         <= 1'b0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      match_q      <= 1'b0;
      mism_q       <= 1'b0;
      err_count_q  <= '0;
      pass_count_q <= '0;
      be_q         <= '0;
`ifdef ERR_CAPTURE_EN
      cap_done_q   <= 1'b0;
      err_addr_q   <= '0;
      err_exp_q    <= '0;
      err_got_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      chk_addr_q   <= chk_addr_d;
      pat_q        <= pat_d;
      loop_q       <= loop_d;
      odd_q        <= odd_d;
      outst_q      <= outst_d;
      pass_err_q   <= pass_err_d;
      req_q        <= req_d;
      rd_q         <= rd_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      match_q      <= match_d;
      mism_q       <= mism_d;
      err_count_q  <= err_count_d;
      pass_count_q <= pass_count_d;
      be_q         <= '1;
`ifdef ERR_CAPTURE_EN
      cap_done_q   <= cap_done_d;
      err_addr_q   <= err_addr_d;
      err_exp_q    <= err_exp_d;
      err_got_q    <= err_got_d;
`endif
    end
  end

  assign ram_req      = req_q;
  assign ram_rd       = rd_q;
  assign ram_addr     = addr_q;
  assign ram_be       = be_q;
  assign ram_wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign ram_match    = match_q;
  assign ram_mismatch = mism_q;
  assign err_count    = err_count_q;
  assign pass_count   = pass_count_q;
`ifdef ERR_CAPTURE_EN
  assign err_addr     = err_addr_q;
  assign err_exp      = err_exp_q;
  assign err_got      = err_got_q;
`endif

endmodule
